// File: rtl/ptw_axi_bridge_if.sv
// ptw_axi_bridge_if -- single-beat AXI read channel (AR + R) used by the
// page-table-walk bridge.
//   master modport : bridge side (drives AR fields and RREADY)
//   slave  modport : memory/interconnect side (drives ARREADY and R fields)
interface ptw_axi_bridge_if #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64
);
  logic                  M_ARVALID;
  logic                  M_ARREADY;
  logic [ADDR_WIDTH-1:0] M_ARADDR;
  logic [7:0]            M_ARLEN;
  logic [2:0]            M_ARSIZE;
  logic [1:0]            M_ARBURST;
  logic [2:0]            M_ARPROT;
  logic                  M_RVALID;
  logic                  M_RREADY;
  logic [DATA_WIDTH-1:0] M_RDATA;
  logic [1:0]            M_RRESP;
  logic                  M_RLAST;

  modport master (
    output M_ARVALID, M_ARADDR, M_ARLEN, M_ARSIZE, M_ARBURST, M_ARPROT, M_RREADY,
    input  M_ARREADY, M_RVALID, M_RDATA, M_RRESP, M_RLAST
  );

  modport slave (
    input  M_ARVALID, M_ARADDR, M_ARLEN, M_ARSIZE, M_ARBURST, M_ARPROT, M_RREADY,
    output M_ARREADY, M_RVALID, M_RDATA, M_RRESP, M_RLAST
  );
endinterface

// File: rtl/ptw_axi_bridge.sv
// ptw_axi_bridge -- arbitrates ITLB and DTLB page-walk PTE reads onto a
// single-beat AXI read master, one transaction outstanding.
// Ports:
//   CLK, RSTN                  : clock, synchronous active-low reset
//   ITLB/DTLB_ADDR_VALID, _ADDR: request pulse and PTE address per requester
//   ITLB/DTLB_DATA_VALID, _DATA: one-cycle response pulse and PTE data
//   ITLB/DTLB_ACCESS_FAULT     : set with DATA_VALID on SLVERR/DECERR
//   BUSY                       : high whenever the FSM is not IDLE
//   axi                        : AXI read master (ptw_axi_bridge_if.master)
module ptw_axi_bridge #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64
) (
  input  logic                  CLK,
  input  logic                  RSTN,
  input  logic                  ITLB_ADDR_VALID,
  input  logic [ADDR_WIDTH-1:0] ITLB_ADDR,
  input  logic                  DTLB_ADDR_VALID,
  input  logic [ADDR_WIDTH-1:0] DTLB_ADDR,
  output logic                  ITLB_DATA_VALID,
  output logic [DATA_WIDTH-1:0] ITLB_DATA,
  output logic                  ITLB_ACCESS_FAULT,
  output logic                  DTLB_DATA_VALID,
  output logic [DATA_WIDTH-1:0] DTLB_DATA,
  output logic                  DTLB_ACCESS_FAULT,
  output logic                  BUSY,
  ptw_axi_bridge_if.master      axi
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    AR   = 2'd1,
    R    = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t                state;
  logic                  owner_d;     // 1: DTLB owns the transaction, 0: ITLB
  logic                  prio_d;      // 1: DTLB wins a contested grant
  logic                  pend_i;
  logic                  pend_d;
  logic [ADDR_WIDTH-1:0] paddr_i;
  logic [ADDR_WIDTH-1:0] paddr_d;
  logic                  ar_valid;
  logic [ADDR_WIDTH-1:0] ar_addr;
  logic                  r_ready;
  logic                  busy;

  logic                  cand_i;
  logic                  cand_d;
  logic                  contested;
  logic                  grant_i;
  logic                  grant_d;
  logic                  accept_i;
  logic                  accept_d;
  logic [ADDR_WIDTH-1:0] grant_addr;
  logic                  resp_err;

  // Arbitration and request-acceptance decode.
  always_comb begin
    cand_i     = pend_i | ITLB_ADDR_VALID;
    cand_d     = pend_d | DTLB_ADDR_VALID;
    contested  = cand_i & cand_d;
    grant_d    = (state == IDLE) & cand_d & (~cand_i | prio_d);
    grant_i    = (state == IDLE) & cand_i & ~grant_d;
    // A pulse is dropped while the same requester is pending or in flight.
    accept_i   = ITLB_ADDR_VALID & ~pend_i & ~((state != IDLE) & ~owner_d);
    accept_d   = DTLB_ADDR_VALID & ~pend_d & ~((state != IDLE) & owner_d);
    // A pending address has precedence: a fresh pulse from a pending
    // requester is ignored, so its address must not be used.
    grant_addr = grant_d ? (pend_d ? paddr_d : DTLB_ADDR)
                         : (pend_i ? paddr_i : ITLB_ADDR);
    resp_err   = axi.M_RRESP[1];
  end

  // FSM, pending capture and all registered outputs.
  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      state             <= IDLE;
      owner_d           <= 1'b0;
      prio_d            <= 1'b1;
      pend_i            <= 1'b0;
      pend_d            <= 1'b0;
      paddr_i           <= {ADDR_WIDTH{1'b0}};
      paddr_d           <= {ADDR_WIDTH{1'b0}};
      ar_valid          <= 1'b0;
      ar_addr           <= {ADDR_WIDTH{1'b0}};
      r_ready           <= 1'b0;
      busy              <= 1'b0;
      ITLB_DATA_VALID   <= 1'b0;
      ITLB_DATA         <= {DATA_WIDTH{1'b0}};
      ITLB_ACCESS_FAULT <= 1'b0;
      DTLB_DATA_VALID   <= 1'b0;
      DTLB_DATA         <= {DATA_WIDTH{1'b0}};
      DTLB_ACCESS_FAULT <= 1'b0;
    end else begin
      // Response outputs are single-cycle pulses; data is zero outside them.
      ITLB_DATA_VALID   <= 1'b0;
      ITLB_DATA         <= {DATA_WIDTH{1'b0}};
      ITLB_ACCESS_FAULT <= 1'b0;
      DTLB_DATA_VALID   <= 1'b0;
      DTLB_DATA         <= {DATA_WIDTH{1'b0}};
      DTLB_ACCESS_FAULT <= 1'b0;

      if (grant_i) begin
        pend_i <= 1'b0;
      end else if (accept_i) begin
        pend_i  <= 1'b1;
        paddr_i <= ITLB_ADDR;
      end else begin
        pend_i <= pend_i;
      end

      if (grant_d) begin
        pend_d <= 1'b0;
      end else if (accept_d) begin
        pend_d  <= 1'b1;
        paddr_d <= DTLB_ADDR;
      end else begin
        pend_d <= pend_d;
      end

      case (state)
        IDLE: begin
          if (grant_i | grant_d) begin
            owner_d  <= grant_d;
            ar_addr  <= {grant_addr[ADDR_WIDTH-1:3], 3'b000};
            ar_valid <= 1'b1;
            busy     <= 1'b1;
            state    <= AR;
            // Priority only moves on a real contest, so an uncontested
            // grant does not cost the other requester its turn.
            if (contested) begin
              prio_d <= ~grant_d;
            end else begin
              prio_d <= prio_d;
            end
          end else begin
            state <= IDLE;
          end
        end
        AR: begin
          if (axi.M_ARREADY) begin
            ar_valid <= 1'b0;
            r_ready  <= 1'b1;
            state    <= R;
          end else begin
            state <= AR;
          end
        end
        R: begin
          if (axi.M_RVALID) begin
            r_ready <= 1'b0;
            state   <= RESP;
            if (owner_d) begin
              DTLB_DATA_VALID   <= 1'b1;
              DTLB_DATA         <= resp_err ? {DATA_WIDTH{1'b0}} : axi.M_RDATA;
              DTLB_ACCESS_FAULT <= resp_err;
            end else begin
              ITLB_DATA_VALID   <= 1'b1;
              ITLB_DATA         <= resp_err ? {DATA_WIDTH{1'b0}} : axi.M_RDATA;
              ITLB_ACCESS_FAULT <= resp_err;
            end
          end else begin
            state <= R;
          end
        end
        RESP: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          ar_valid <= 1'b0;
          r_ready  <= 1'b0;
          busy     <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

  assign axi.M_ARVALID = ar_valid;
  assign axi.M_ARADDR  = ar_addr;
  assign axi.M_ARLEN   = 8'd0;
  assign axi.M_ARSIZE  = 3'b011;
  assign axi.M_ARBURST = 2'b01;
  assign axi.M_ARPROT  = 3'b001;
  assign axi.M_RREADY  = r_ready;
  assign BUSY          = busy;

endmodule

// File: tb/tb_ptw_axi_bridge.sv
// tb_ptw_axi_bridge -- directed self-checking bench for ptw_axi_bridge.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_ptw_axi_bridge;
  localparam int AW = 64;
  localparam int DW = 64;

  logic          CLK;
  logic          RSTN;
  logic          ITLB_ADDR_VALID;
  logic [AW-1:0] ITLB_ADDR;
  logic          DTLB_ADDR_VALID;
  logic [AW-1:0] DTLB_ADDR;
  logic          ITLB_DATA_VALID;
  logic [DW-1:0] ITLB_DATA;
  logic          ITLB_ACCESS_FAULT;
  logic          DTLB_DATA_VALID;
  logic [DW-1:0] DTLB_DATA;
  logic          DTLB_ACCESS_FAULT;
  logic          BUSY;

  int vectors;
  int miscompares;

  ptw_axi_bridge_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) axi ();

  ptw_axi_bridge #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .CLK(CLK), .RSTN(RSTN),
    .ITLB_ADDR_VALID(ITLB_ADDR_VALID), .ITLB_ADDR(ITLB_ADDR),
    .DTLB_ADDR_VALID(DTLB_ADDR_VALID), .DTLB_ADDR(DTLB_ADDR),
    .ITLB_DATA_VALID(ITLB_DATA_VALID), .ITLB_DATA(ITLB_DATA),
    .ITLB_ACCESS_FAULT(ITLB_ACCESS_FAULT),
    .DTLB_DATA_VALID(DTLB_DATA_VALID), .DTLB_DATA(DTLB_DATA),
    .DTLB_ACCESS_FAULT(DTLB_ACCESS_FAULT),
    .BUSY(BUSY),
    .axi(axi.master)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic tick();
    @(negedge CLK);
  endtask

  // Memory-side responder: waits (bounded) for ARVALID, accepts it at once,
  // returns one R beat the next cycle and leaves the bench in the response
  // cycle. found=0 means ARVALID never showed up.
  task automatic serve(input logic [DW-1:0] data, input logic [1:0] resp,
                       output logic found, output logic [AW-1:0] addr);
    found = 1'b0;
    addr  = '0;
    for (int i = 0; i < 10; i++) begin
      if (axi.M_ARVALID === 1'b1) begin
        addr = axi.M_ARADDR;
        axi.M_ARREADY = 1'b1;
        tick();
        axi.M_ARREADY = 1'b0;
        axi.M_RVALID = 1'b1;
        axi.M_RDATA = data;
        axi.M_RRESP = resp;
        axi.M_RLAST = 1'b1;
        tick();
        axi.M_RVALID = 1'b0;
        axi.M_RLAST = 1'b0;
        found = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    RSTN = 1'b0;
    tick(); tick();
    vectors++; if (BUSY !== 1'b0) begin miscompares++; $display("FAIL rst_busy: got %b want 0", BUSY); end
    vectors++; if (axi.M_ARVALID !== 1'b0) begin miscompares++; $display("FAIL rst_arvalid: got %b want 0", axi.M_ARVALID); end
    vectors++; if (axi.M_RREADY !== 1'b0) begin miscompares++; $display("FAIL rst_rready: got %b want 0", axi.M_RREADY); end
    vectors++; if ({ITLB_DATA_VALID, DTLB_DATA_VALID, ITLB_ACCESS_FAULT, DTLB_ACCESS_FAULT} !== 4'b0000) begin
      miscompares++; $display("FAIL rst_pulses: got %b want 0000", {ITLB_DATA_VALID, DTLB_DATA_VALID, ITLB_ACCESS_FAULT, DTLB_ACCESS_FAULT}); end
    vectors++; if ((ITLB_DATA | DTLB_DATA) !== 64'h0) begin miscompares++; $display("FAIL rst_data: got %h/%h want 0", ITLB_DATA, DTLB_DATA); end
    RSTN = 1'b1;
    tick();
  endtask

  task automatic test_basic_dtlb();
    DTLB_ADDR_VALID = 1'b1; DTLB_ADDR = 64'h0000_0000_8000_1005;
    tick();                                   // cycle 1
    DTLB_ADDR_VALID = 1'b0;
    vectors++; if (axi.M_ARVALID !== 1'b1) begin miscompares++; $display("FAIL basic_arvalid: got %b want 1", axi.M_ARVALID); end
    vectors++; if (axi.M_ARADDR !== 64'h0000_0000_8000_1000) begin miscompares++; $display("FAIL basic_araddr: got %h want 0000000080001000", axi.M_ARADDR); end
    vectors++; if ({axi.M_ARLEN, axi.M_ARSIZE, axi.M_ARBURST, axi.M_ARPROT} !== {8'd0, 3'b011, 2'b01, 3'b001}) begin
      miscompares++; $display("FAIL basic_arconst: got %h/%b/%b/%b want 00/011/01/001", axi.M_ARLEN, axi.M_ARSIZE, axi.M_ARBURST, axi.M_ARPROT); end
    vectors++; if (BUSY !== 1'b1) begin miscompares++; $display("FAIL basic_busy: got %b want 1", BUSY); end
    axi.M_ARREADY = 1'b1;
    tick();                                   // cycle 2
    axi.M_ARREADY = 1'b0;
    vectors++; if ({axi.M_ARVALID, axi.M_RREADY} !== 2'b01) begin miscompares++; $display("FAIL basic_rready: got arvalid,rready=%b want 01", {axi.M_ARVALID, axi.M_RREADY}); end
    axi.M_RVALID = 1'b1; axi.M_RDATA = 64'h0000_0000_2000_0CF1; axi.M_RRESP = 2'b00; axi.M_RLAST = 1'b1;
    tick();                                   // cycle 3
    axi.M_RVALID = 1'b0; axi.M_RLAST = 1'b0;
    vectors++; if (DTLB_DATA_VALID !== 1'b1) begin miscompares++; $display("FAIL basic_dvalid: got %b want 1", DTLB_DATA_VALID); end
    vectors++; if (DTLB_DATA !== 64'h0000_0000_2000_0CF1) begin miscompares++; $display("FAIL basic_ddata: got %h want 0000000020000cf1", DTLB_DATA); end
    vectors++; if ({ITLB_DATA_VALID, ITLB_ACCESS_FAULT, DTLB_ACCESS_FAULT} !== 3'b000 || ITLB_DATA !== 64'h0) begin
      miscompares++; $display("FAIL basic_itlb_quiet: got ivalid,ifault,dfault=%b idata=%h want 000/0", {ITLB_DATA_VALID, ITLB_ACCESS_FAULT, DTLB_ACCESS_FAULT}, ITLB_DATA); end
    tick();                                   // cycle 4
    vectors++; if ({DTLB_DATA_VALID, BUSY} !== 2'b00 || DTLB_DATA !== 64'h0) begin
      miscompares++; $display("FAIL basic_after: got dvalid,busy=%b ddata=%h want 00/0", {DTLB_DATA_VALID, BUSY}, DTLB_DATA); end
  endtask

  task automatic test_simultaneous();
    logic found; logic [AW-1:0] a;
    for (int pair = 0; pair < 2; pair++) begin
      ITLB_ADDR_VALID = 1'b1; ITLB_ADDR = 64'h0000_0000_1000_0008;
      DTLB_ADDR_VALID = 1'b1; DTLB_ADDR = 64'h0000_0000_2000_0010;
      tick();
      ITLB_ADDR_VALID = 1'b0; DTLB_ADDR_VALID = 1'b0;
      // First pair after reset: DTLB first; second pair: ITLB first.
      serve(64'h0000_0000_0000_0A01, 2'b00, found, a);
      vectors++; if (found !== 1'b1 || a !== (pair == 0 ? 64'h2000_0010 : 64'h1000_0008)) begin
        miscompares++; $display("FAIL simul%0d_first: got found=%b addr=%h want 1/%h", pair, found, a, (pair == 0 ? 64'h2000_0010 : 64'h1000_0008)); end
      vectors++; if ({ITLB_DATA_VALID, DTLB_DATA_VALID} !== (pair == 0 ? 2'b01 : 2'b10)) begin
        miscompares++; $display("FAIL simul%0d_first_owner: got ivalid,dvalid=%b want %b", pair, {ITLB_DATA_VALID, DTLB_DATA_VALID}, (pair == 0 ? 2'b01 : 2'b10)); end
      tick();                                 // IDLE cycle, pending requester granted here
      vectors++; if ({BUSY, axi.M_ARVALID} !== 2'b00) begin miscompares++; $display("FAIL simul%0d_idle: got busy,arvalid=%b want 00", pair, {BUSY, axi.M_ARVALID}); end
      tick();
      vectors++; if (axi.M_ARVALID !== 1'b1) begin miscompares++; $display("FAIL simul%0d_second_ar: got %b want 1", pair, axi.M_ARVALID); end
      serve(64'h0000_0000_0000_0B02, 2'b00, found, a);
      vectors++; if (found !== 1'b1 || a !== (pair == 0 ? 64'h1000_0008 : 64'h2000_0010)) begin
        miscompares++; $display("FAIL simul%0d_second: got found=%b addr=%h want 1/%h", pair, found, a, (pair == 0 ? 64'h1000_0008 : 64'h2000_0010)); end
      vectors++; if ({ITLB_DATA_VALID, DTLB_DATA_VALID} !== (pair == 0 ? 2'b10 : 2'b01) || (ITLB_DATA | DTLB_DATA) !== 64'h0B02) begin
        miscompares++; $display("FAIL simul%0d_second_owner: got ivalid,dvalid=%b data=%h want %b/0b02", pair, {ITLB_DATA_VALID, DTLB_DATA_VALID}, ITLB_DATA | DTLB_DATA, (pair == 0 ? 2'b10 : 2'b01)); end
      tick();
    end
  endtask

  task automatic test_ar_stall();
    DTLB_ADDR_VALID = 1'b1; DTLB_ADDR = 64'h0000_0000_4000_0ABC;
    tick();
    DTLB_ADDR_VALID = 1'b0;
    for (int c = 0; c < 5; c++) begin
      vectors++; if (axi.M_ARVALID !== 1'b1 || axi.M_ARADDR !== 64'h0000_0000_4000_0AB8) begin
        miscompares++; $display("FAIL stall_c%0d: got arvalid=%b araddr=%h want 1/0000000040000ab8", c, axi.M_ARVALID, axi.M_ARADDR); end
      tick();
    end
    axi.M_ARREADY = 1'b1;
    tick();
    axi.M_ARREADY = 1'b0;
    vectors++; if ({axi.M_ARVALID, axi.M_RREADY, DTLB_DATA_VALID} !== 3'b010) begin
      miscompares++; $display("FAIL stall_r: got arvalid,rready,dvalid=%b want 010", {axi.M_ARVALID, axi.M_RREADY, DTLB_DATA_VALID}); end
    axi.M_RVALID = 1'b1; axi.M_RDATA = 64'h0000_0000_1234_5671; axi.M_RRESP = 2'b00;
    tick();
    axi.M_RVALID = 1'b0;
    vectors++; if (DTLB_DATA_VALID !== 1'b1 || DTLB_DATA !== 64'h0000_0000_1234_5671) begin
      miscompares++; $display("FAIL stall_resp: got dvalid=%b ddata=%h want 1/0000000012345671", DTLB_DATA_VALID, DTLB_DATA); end
    tick();
  endtask

  task automatic test_fault();
    logic found; logic [AW-1:0] a;
    ITLB_ADDR_VALID = 1'b1; ITLB_ADDR = 64'h0000_0000_0000_3000;
    tick();
    ITLB_ADDR_VALID = 1'b0;
    serve(64'hFFFF_FFFF_FFFF_FFFF, 2'b10, found, a);
    vectors++; if (found !== 1'b1 || a !== 64'h3000) begin miscompares++; $display("FAIL fault_ar: got found=%b addr=%h want 1/3000", found, a); end
    vectors++; if ({ITLB_DATA_VALID, ITLB_ACCESS_FAULT, DTLB_DATA_VALID, DTLB_ACCESS_FAULT} !== 4'b1100 || ITLB_DATA !== 64'h0) begin
      miscompares++; $display("FAIL fault_resp: got iv,if,dv,df=%b idata=%h want 1100/0", {ITLB_DATA_VALID, ITLB_ACCESS_FAULT, DTLB_DATA_VALID, DTLB_ACCESS_FAULT}, ITLB_DATA); end
    tick();
    vectors++; if ({ITLB_DATA_VALID, ITLB_ACCESS_FAULT} !== 2'b00) begin
      miscompares++; $display("FAIL fault_oneshot: got iv,if=%b want 00", {ITLB_DATA_VALID, ITLB_ACCESS_FAULT}); end
  endtask

  task automatic test_pending_in_r();
    logic found; logic [AW-1:0] a;
    DTLB_ADDR_VALID = 1'b1; DTLB_ADDR = 64'h0000_0000_5000_0020;
    tick();
    DTLB_ADDR_VALID = 1'b0;
    axi.M_ARREADY = 1'b1;
    tick();                                   // R state
    axi.M_ARREADY = 1'b0;
    ITLB_ADDR_VALID = 1'b1; ITLB_ADDR = 64'h0000_0000_6000_0047;
    // Own-requester pulse while in flight must be ignored.
    DTLB_ADDR_VALID = 1'b1; DTLB_ADDR = 64'h0000_0000_7777_0000;
    tick();
    ITLB_ADDR_VALID = 1'b0; DTLB_ADDR_VALID = 1'b0;
    axi.M_RVALID = 1'b1; axi.M_RDATA = 64'h0000_0000_0000_0D01; axi.M_RRESP = 2'b00;
    tick();                                   // RESP
    axi.M_RVALID = 1'b0;
    vectors++; if (DTLB_DATA_VALID !== 1'b1 || DTLB_DATA !== 64'h0D01) begin
      miscompares++; $display("FAIL pend_dresp: got dvalid=%b ddata=%h want 1/0d01", DTLB_DATA_VALID, DTLB_DATA); end
    tick();                                   // IDLE
    tick();                                   // AR for pending ITLB
    vectors++; if (axi.M_ARVALID !== 1'b1 || axi.M_ARADDR !== 64'h0000_0000_6000_0040) begin
      miscompares++; $display("FAIL pend_itlb_ar: got arvalid=%b araddr=%h want 1/0000000060000040", axi.M_ARVALID, axi.M_ARADDR); end
    serve(64'h0000_0000_0000_0E02, 2'b00, found, a);
    vectors++; if (found !== 1'b1 || ITLB_DATA_VALID !== 1'b1 || ITLB_DATA !== 64'h0E02) begin
      miscompares++; $display("FAIL pend_iresp: got found=%b ivalid=%b idata=%h want 1/1/0e02", found, ITLB_DATA_VALID, ITLB_DATA); end
    tick();
    tick();
    vectors++; if ({BUSY, axi.M_ARVALID} !== 2'b00) begin
      miscompares++; $display("FAIL pend_no_dtlb_replay: got busy,arvalid=%b want 00", {BUSY, axi.M_ARVALID}); end
  endtask

  task automatic test_reset_mid();
    DTLB_ADDR_VALID = 1'b1; DTLB_ADDR = 64'h0000_0000_8800_0000;
    tick();
    DTLB_ADDR_VALID = 1'b0;
    axi.M_ARREADY = 1'b1;
    tick();                                   // R state
    axi.M_ARREADY = 1'b0;
    RSTN = 1'b0;
    tick();
    RSTN = 1'b1;
    axi.M_RVALID = 1'b1; axi.M_RDATA = 64'h0000_0000_0000_0F0F; axi.M_RRESP = 2'b00;
    vectors++; if ({BUSY, axi.M_RREADY} !== 2'b00) begin
      miscompares++; $display("FAIL rstmid_state: got busy,rready=%b want 00", {BUSY, axi.M_RREADY}); end
    tick();
    axi.M_RVALID = 1'b0;
    vectors++; if ({ITLB_DATA_VALID, DTLB_DATA_VALID, BUSY, axi.M_RREADY, axi.M_ARVALID} !== 5'b00000) begin
      miscompares++; $display("FAIL rstmid_nopulse: got iv,dv,busy,rready,arvalid=%b want 00000", {ITLB_DATA_VALID, DTLB_DATA_VALID, BUSY, axi.M_RREADY, axi.M_ARVALID}); end
    tick();
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    RSTN = 1'b0;
    ITLB_ADDR_VALID = 1'b0; ITLB_ADDR = '0;
    DTLB_ADDR_VALID = 1'b0; DTLB_ADDR = '0;
    axi.M_ARREADY = 1'b0; axi.M_RVALID = 1'b0; axi.M_RDATA = '0;
    axi.M_RRESP = 2'b00; axi.M_RLAST = 1'b0;
    test_reset();
    test_basic_dtlb();
    // Fresh reset so arbitration priority starts at DTLB.
    test_reset();
    test_simultaneous();
    test_ar_stall();
    test_fault();
    test_pending_in_r();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
